// File: rtl/bist_pkg.sv
// Shared definitions for the BIST output response analyzer.
//   bist_state_e : analyzer FSM states
//   BIST_RESP_W  : packed CUT response width
//   DEFAULT_POLY : default MISR feedback taps (x^16+x^12+x^5+1)
//   DEFAULT_SEED : default MISR seed
//   pack_resp()  : builds the response word from the four CUT signals
package bist_pkg;

    localparam int unsigned BIST_RESP_W = 9;
    localparam logic [15:0] DEFAULT_POLY = 16'h1021;
    localparam logic [15:0] DEFAULT_SEED = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_COMPARE = 2'd2,
        ST_DONE    = 2'd3
    } bist_state_e;

    // {cut_fz_L, cut_lclk, cut_read_a[4:0], cut_test_out[1:0]}
    function automatic logic [BIST_RESP_W-1:0] pack_resp(
        input logic       fz_l,
        input logic       lclk,
        input logic [4:0] read_a,
        input logic [1:0] test_out
    );
        return {fz_l, lclk, read_a, test_out};
    endfunction

endpackage

// File: rtl/bist_signature_analyzer_misr.sv
// Multiple-input signature register.
//   i_clock     : clock
//   i_reset     : synchronous active-high reset, loads SEED
//   i_load_seed : reload SEED (priority over shift)
//   i_shift_en  : fold i_din into the signature
//   i_din       : zero-extended response word
//   o_signature : current MISR contents
module misr_reg #(
    parameter int unsigned      SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = 16'h1021,
    parameter logic [SIG_W-1:0] SEED  = 16'h0000
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_load_seed,
    input  logic             i_shift_en,
    input  logic [SIG_W-1:0] i_din,
    output logic [SIG_W-1:0] o_signature
);

    logic [SIG_W-1:0] r_sig;
    logic [SIG_W-1:0] w_next;

    // Galois-style shift with feedback on the outgoing MSB, then XOR in data.
    assign w_next = {r_sig[SIG_W-2:0], 1'b0}
                  ^ (r_sig[SIG_W-1] ? POLY : '0)
                  ^ i_din;

    always_ff @(posedge i_clock) begin
        if (i_reset || i_load_seed) begin
            r_sig <= SEED;
        end else if (i_shift_en) begin
            r_sig <= w_next;
        end
    end

    assign o_signature = r_sig;

endmodule

// File: rtl/bist_signature_analyzer.sv
// BIST output response analyzer: compacts CUT responses into a MISR over a
// session and compares the final signature against GOLDEN.
//   clock, reset : clock and synchronous active-high reset
//   start        : begin a session (honoured in IDLE and DONE)
//   capture_en   : cut_resp valid this cycle
//   last         : current valid sample is the final one
//   cut_resp     : CUT response word
//   signature    : current MISR contents
//   busy         : high in CAPTURE and COMPARE
//   bist_end     : session complete (held in DONE)
//   pass_nfail   : final signature matched GOLDEN without timeout
//   timeout      : session ended by the sample watchdog
module bist_signature_analyzer
    import bist_pkg::*;
#(
    parameter int unsigned      RESP_W      = BIST_RESP_W,
    parameter int unsigned      SIG_W       = 16,
    parameter logic [SIG_W-1:0] POLY        = SIG_W'(DEFAULT_POLY),
    parameter logic [SIG_W-1:0] SEED        = SIG_W'(DEFAULT_SEED),
    parameter logic [SIG_W-1:0] GOLDEN      = '0,
    parameter int unsigned      MAX_SAMPLES = 256
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              capture_en,
    input  logic              last,
    input  logic [RESP_W-1:0] cut_resp,
    output logic [SIG_W-1:0]  signature,
    output logic              busy,
    output logic              bist_end,
    output logic              pass_nfail,
    output logic              timeout
);

    localparam int unsigned CNT_W = $clog2(MAX_SAMPLES + 1);

    bist_state_e      r_state;
    logic [CNT_W-1:0] r_count;
    logic             r_busy;
    logic             r_end;
    logic             r_pass;
    logic             r_timeout;

    logic             w_start_ok;
    logic             w_accept;
    logic [CNT_W-1:0] w_count_inc;
    logic [SIG_W-1:0] w_sig;

    assign w_start_ok  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_accept    = capture_en && (r_state == ST_CAPTURE);
    assign w_count_inc = r_count + CNT_W'(1);

    misr_reg #(
        .SIG_W (SIG_W),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_misr (
        .i_clock     (clock),
        .i_reset     (reset),
        .i_load_seed (w_start_ok),
        .i_shift_en  (w_accept),
        .i_din       (SIG_W'(cut_resp)),
        .o_signature (w_sig)
    );

    // Session FSM, sample counter and final compare.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_count   <= '0;
            r_busy    <= 1'b0;
            r_end     <= 1'b0;
            r_pass    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state   <= ST_CAPTURE;
                        r_count   <= '0;
                        r_busy    <= 1'b1;
                        r_end     <= 1'b0;
                        r_pass    <= 1'b0;
                        r_timeout <= 1'b0;
                    end
                end
                ST_CAPTURE: begin
                    if (capture_en) begin
                        r_count <= w_count_inc;
                        // last takes precedence over the watchdog on the same sample
                        if (last) begin
                            r_state <= ST_COMPARE;
                        end else if (w_count_inc == CNT_W'(MAX_SAMPLES)) begin
                            r_state   <= ST_COMPARE;
                            r_timeout <= 1'b1;
                        end
                    end
                end
                ST_COMPARE: begin
                    r_state <= ST_DONE;
                    r_busy  <= 1'b0;
                    r_end   <= 1'b1;
                    r_pass  <= (w_sig == GOLDEN) && !r_timeout;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign signature  = w_sig;
    assign busy       = r_busy;
    assign bist_end   = r_end;
    assign pass_nfail = r_pass;
    assign timeout    = r_timeout;

endmodule

// File: tb/tb_bist_signature_analyzer.sv
// Self-checking bench: four analyzers with different GOLDEN / MAX_SAMPLES
// share one stimulus stream and are checked every cycle against a
// session-level reference model, plus literal checks on directed scenarios.
module tb_bist_signature_analyzer;

    localparam int NDUT = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       capture_en = 1'b0;
    logic       last = 1'b0;
    logic [8:0] cut_resp = '0;

    logic [NDUT-1:0][15:0] sig_o;
    logic [NDUT-1:0]       busy_o;
    logic [NDUT-1:0]       end_o;
    logic [NDUT-1:0]       pass_o;
    logic [NDUT-1:0]       to_o;

    int  n_tests = 0;
    int  n_fail  = 0;
    bit  chk_en  = 1'b0;

    always #5 clock = ~clock;

    // dut 0: GOLDEN 0002, dut 1: GOLDEN 0003, dut 2: GOLDEN 1021, dut 3: GOLDEN 0000 / MAX 4
    bist_signature_analyzer #(.GOLDEN(16'h0002), .MAX_SAMPLES(256)) u_dut0 (
        .clock(clock), .reset(reset), .start(start), .capture_en(capture_en),
        .last(last), .cut_resp(cut_resp), .signature(sig_o[0]), .busy(busy_o[0]),
        .bist_end(end_o[0]), .pass_nfail(pass_o[0]), .timeout(to_o[0]));
    bist_signature_analyzer #(.GOLDEN(16'h0003), .MAX_SAMPLES(256)) u_dut1 (
        .clock(clock), .reset(reset), .start(start), .capture_en(capture_en),
        .last(last), .cut_resp(cut_resp), .signature(sig_o[1]), .busy(busy_o[1]),
        .bist_end(end_o[1]), .pass_nfail(pass_o[1]), .timeout(to_o[1]));
    bist_signature_analyzer #(.GOLDEN(16'h1021), .MAX_SAMPLES(256)) u_dut2 (
        .clock(clock), .reset(reset), .start(start), .capture_en(capture_en),
        .last(last), .cut_resp(cut_resp), .signature(sig_o[2]), .busy(busy_o[2]),
        .bist_end(end_o[2]), .pass_nfail(pass_o[2]), .timeout(to_o[2]));
    bist_signature_analyzer #(.GOLDEN(16'h0000), .MAX_SAMPLES(4)) u_dut3 (
        .clock(clock), .reset(reset), .start(start), .capture_en(capture_en),
        .last(last), .cut_resp(cut_resp), .signature(sig_o[3]), .busy(busy_o[3]),
        .bist_end(end_o[3]), .pass_nfail(pass_o[3]), .timeout(to_o[3]));

    function automatic logic [15:0] golden_of(input int d);
        case (d)
            0:       return 16'h0002;
            1:       return 16'h0003;
            2:       return 16'h1021;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic int max_of(input int d);
        return (d == 3) ? 4 : 256;
    endfunction

    // Signature as polynomial arithmetic: multiply by x mod P, add the response.
    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [8:0] r);
        int t;
        t = int'(s) * 2;
        if (t >= 65536) t = (t - 65536) ^ 32'h1021;
        return 16'(t) ^ {7'b0, r};
    endfunction

    // Reference model: session phase 0 idle, 1 capturing, 2 comparing, 3 done.
    int          m_ph  [NDUT];
    logic [15:0] m_sig [NDUT];
    int          m_cnt [NDUT];
    bit          m_busy[NDUT];
    bit          m_end [NDUT];
    bit          m_pass[NDUT];
    bit          m_to  [NDUT];

    always @(posedge clock) begin
        for (int d = 0; d < NDUT; d++) begin
            int          ph;
            logic [15:0] sg;
            int          cn;
            bit          bz, en, ps, tm;
            ph = m_ph[d]; sg = m_sig[d]; cn = m_cnt[d];
            bz = m_busy[d]; en = m_end[d]; ps = m_pass[d]; tm = m_to[d];
            if (reset) begin
                ph = 0; sg = 16'h0000; cn = 0; bz = 0; en = 0; ps = 0; tm = 0;
            end else if ((ph == 0 || ph == 3) && start) begin
                ph = 1; sg = 16'h0000; cn = 0; bz = 1; en = 0; ps = 0; tm = 0;
            end else if (ph == 1 && capture_en) begin
                sg = misr_step(sg, cut_resp);
                cn = cn + 1;
                if (last) ph = 2;
                else if (cn == max_of(d)) begin ph = 2; tm = 1; end
            end else if (ph == 2) begin
                ph = 3; bz = 0; en = 1; ps = (sg == golden_of(d)) && !tm;
            end
            m_ph[d] <= ph; m_sig[d] <= sg; m_cnt[d] <= cn;
            m_busy[d] <= bz; m_end[d] <= en; m_pass[d] <= ps; m_to[d] <= tm;
        end
    end

    // Cycle-by-cycle comparison of every DUT against the model.
    always @(negedge clock) begin
        if (chk_en) begin
            for (int d = 0; d < NDUT; d++) begin
                n_tests += 5;
                if (sig_o[d] !== m_sig[d]) begin
                    n_fail++;
                    $display("FAIL model_signature dut%0d t=%0t got %h want %h", d, $time, sig_o[d], m_sig[d]);
                end
                if (busy_o[d] !== m_busy[d]) begin
                    n_fail++;
                    $display("FAIL model_busy dut%0d t=%0t got %b want %b", d, $time, busy_o[d], m_busy[d]);
                end
                if (end_o[d] !== m_end[d]) begin
                    n_fail++;
                    $display("FAIL model_bist_end dut%0d t=%0t got %b want %b", d, $time, end_o[d], m_end[d]);
                end
                if (pass_o[d] !== m_pass[d]) begin
                    n_fail++;
                    $display("FAIL model_pass_nfail dut%0d t=%0t got %b want %b", d, $time, pass_o[d], m_pass[d]);
                end
                if (to_o[d] !== m_to[d]) begin
                    n_fail++;
                    $display("FAIL model_timeout dut%0d t=%0t got %b want %b", d, $time, to_o[d], m_to[d]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s t=%0t got %h want %h", name, $time, got, want);
        end
    endtask

    // Apply inputs for one edge; returns 2 time units after that edge.
    task automatic drive(input bit rs, input bit st, input bit ce, input bit la, input logic [8:0] rv);
        reset = rs; start = st; capture_en = ce; last = la; cut_resp = rv;
        @(posedge clock);
        #2;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 9'h000);
    endtask

    task automatic sample(input logic [8:0] rv, input bit la);
        drive(1'b0, 1'b0, 1'b1, la, rv);
    endtask

    initial begin
        // reset held 10 cycles
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 9'h000);
            chk_en = 1'b1;
        end
        chk("reset_signature", sig_o[0], 16'h0000);
        chk("reset_flags", 16'({busy_o[0], end_o[0], pass_o[0], to_o[0]}), 16'h0000);

        // pass / fail session: 9'h001 then 9'h000 with last
        drive(1'b0, 1'b1, 1'b0, 1'b0, 9'h000);
        chk("start_busy", 16'(busy_o[0]), 16'h0001);
        sample(9'h001, 1'b0);
        sample(9'h000, 1'b1);
        chk("pass_signature", sig_o[0], 16'h0002);
        chk("pass_end_not_yet", 16'(end_o[0]), 16'h0000);
        idle();
        chk("pass_bist_end", 16'(end_o[0]), 16'h0001);
        chk("pass_pass_nfail", 16'(pass_o[0]), 16'h0001);
        chk("fail_bist_end", 16'(end_o[1]), 16'h0001);
        chk("fail_pass_nfail", 16'(pass_o[1]), 16'h0000);
        chk("fail_timeout", 16'(to_o[1]), 16'h0000);
        chk("done_busy", 16'(busy_o[0]), 16'h0000);
        idle();

        // feedback path, started from DONE
        drive(1'b0, 1'b1, 1'b0, 1'b0, 9'h000);
        chk("restart_clears_end", 16'(end_o[2]), 16'h0000);
        sample(9'h001, 1'b0);
        for (int i = 0; i < 15; i++) sample(9'h000, 1'b0);
        chk("feedback_msb", sig_o[2], 16'h8000);
        sample(9'h000, 1'b1);
        chk("feedback_poly", sig_o[2], 16'h1021);
        idle();
        chk("feedback_pass", 16'({end_o[2], pass_o[2]}), 16'h0003);
        idle();

        // watchdog on dut 3 (MAX 4): signature equals GOLDEN but timed out
        drive(1'b0, 1'b1, 1'b0, 1'b0, 9'h000);
        for (int i = 0; i < 4; i++) sample(9'h000, 1'b0);
        idle();
        chk("wd_flags", 16'({end_o[3], to_o[3], pass_o[3]}), 16'h0006);
        chk("wd_signature", sig_o[3], 16'h0000);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 9'h000);
        for (int i = 0; i < 3; i++) sample(9'h000, 1'b0);
        sample(9'h000, 1'b1);
        idle();
        chk("wd_last_wins", 16'({end_o[3], to_o[3], pass_o[3]}), 16'h0005);

        // capture_en / last in IDLE are ignored
        drive(1'b1, 1'b0, 1'b0, 1'b0, 9'h000);
        sample(9'h1FF, 1'b1);
        sample(9'h0A5, 1'b0);
        chk("idle_ignores_capture", sig_o[0], 16'h0000);
        chk("idle_no_end", 16'({busy_o[0], end_o[0]}), 16'h0000);

        // start mid-CAPTURE ignored, then reset mid-CAPTURE
        drive(1'b0, 1'b1, 1'b0, 1'b0, 9'h000);
        sample(9'h001, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 9'h000);
        chk("start_mid_capture", sig_o[0], 16'h0002);
        chk("start_mid_busy", 16'(busy_o[0]), 16'h0001);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 9'h001);
        chk("reset_mid_signature", sig_o[0], 16'h0000);
        chk("reset_mid_busy", 16'(busy_o[0]), 16'h0000);

        // randomized traffic, checked by the model every cycle
        for (int i = 0; i < 4000; i++) begin
            bit          rs, st, ce, la;
            logic [8:0]  rv;
            rs = ($urandom_range(0, 199) == 0);
            st = ($urandom_range(0, 9) == 0);
            ce = ($urandom_range(0, 9) < 6);
            la = ($urandom_range(0, 19) == 0);
            rv = bist_pkg::pack_resp(1'($urandom), 1'($urandom), 5'($urandom), 2'($urandom));
            drive(rs, st, ce, la, rv);
        end

        idle();
        idle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
